// File: rtl/fw_rule_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fw_rule_scheduler_if
// Description : Parser header fields, rule-table configuration and verdict
//               signals of the firewall rule scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface fw_rule_scheduler_if #(
    parameter int AW = 4
);
    logic           hdr_ready;
    logic [15:0]    eth_proto;
    logic [7:0]     ip_proto;
    logic [31:0]    src_ip;
    logic [31:0]    dst_ip;
    logic [15:0]    dst_port;
    logic           is_fragment;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [169:0]   cfg_wdata;
    logic           cfg_busy;
    logic           verdict_valid;
    logic           verdict_permit;
    logic           verdict_hit;
    logic [AW-1:0]  verdict_rule;
    logic           overrun;

    modport master (
        output hdr_ready, eth_proto, ip_proto, src_ip, dst_ip, dst_port, is_fragment,
        output cfg_we, cfg_addr, cfg_wdata,
        input  cfg_busy, verdict_valid, verdict_permit, verdict_hit, verdict_rule, overrun
    );

    modport slave (
        input  hdr_ready, eth_proto, ip_proto, src_ip, dst_ip, dst_port, is_fragment,
        input  cfg_we, cfg_addr, cfg_wdata,
        output cfg_busy, verdict_valid, verdict_permit, verdict_hit, verdict_rule, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fw_rule_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fw_rule_scheduler
// Description : Scans the firewall rule table one entry per clock against a
//               snapshot of parser header fields; first match wins.
//               Optional statistics counters enabled by FW_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_rule_scheduler #(
    parameter int RULES          = 16,
    parameter int AW             = 4,
    parameter int DEFAULT_PERMIT = 0,
    parameter int NONIP_PERMIT   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fw_rule_scheduler_if.slave   bus
`ifdef FW_STATS_EN
    ,
    output logic [31:0]          permit_cnt,
    output logic [31:0]          drop_cnt,
    output logic [15:0]          overrun_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX   = AW'(RULES - 1);
    localparam logic [15:0]   ETH_IPV4   = 16'h0800;
    localparam logic          DEF_VERDICT   = (DEFAULT_PERMIT != 0);
    localparam logic          NONIP_VERDICT = (NONIP_PERMIT != 0);

    state_t         state;
    state_t         state_nx;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_nx;

    logic           hdr_ready_q;
    logic           rise;

    // Rule table: only the valid bits need reset; payload is don't-care when invalid
    logic [RULES-1:0] rule_valid;
    logic [168:0]     rule_data [RULES];
    logic             wr_en;

    logic [7:0]     snap_ip_proto;
    logic [31:0]    snap_src_ip;
    logic [31:0]    snap_dst_ip;
    logic [15:0]    snap_dport;
    logic           snap_frag;
    logic           snap_load;

    logic [168:0]   cur;
    logic           cur_valid;
    logic           cur_action;
    logic [31:0]    cur_src_ip;
    logic [31:0]    cur_src_mask;
    logic [31:0]    cur_dst_ip;
    logic [31:0]    cur_dst_mask;
    logic [7:0]     cur_proto;
    logic [15:0]    cur_lo;
    logic [15:0]    cur_hi;
    logic           is_l4;
    logic           port_ok;
    logic           match;

    logic           vd_load;
    logic           vd_permit_nx;
    logic           vd_hit_nx;
    logic [AW-1:0]  vd_rule_nx;
    logic           verdict_valid;
    logic           verdict_permit;
    logic           verdict_hit;
    logic [AW-1:0]  verdict_rule;
    logic           overrun;

    assign rise  = bus.hdr_ready & ~hdr_ready_q;
    assign wr_en = bus.cfg_we && (state == ST_IDLE) &&
                   ({{(32-AW){1'b0}}, bus.cfg_addr} < 32'(RULES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_ready_q <= 1'b0;
        end else begin
            hdr_ready_q <= bus.hdr_ready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rule_valid <= '0;
        end else if (wr_en) begin
            rule_valid[bus.cfg_addr] <= bus.cfg_wdata[169];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rule_data[bus.cfg_addr] <= bus.cfg_wdata[168:0];
        end
    end

    // Rule under evaluation, unpacked from the stored entry
    assign cur          = rule_data[idx];
    assign cur_valid    = rule_valid[idx];
    assign cur_action   = cur[168];
    assign cur_src_ip   = cur[167:136];
    assign cur_src_mask = cur[135:104];
    assign cur_dst_ip   = cur[103:72];
    assign cur_dst_mask = cur[71:40];
    assign cur_proto    = cur[39:32];
    assign cur_lo       = cur[31:16];
    assign cur_hi       = cur[15:0];

    // Fragments and non-TCP/UDP carry no trustworthy port: only a full-range rule passes
    assign is_l4   = ((snap_ip_proto == 8'd6) || (snap_ip_proto == 8'd17)) && !snap_frag;
    assign port_ok = is_l4 ? ((snap_dport >= cur_lo) && (snap_dport <= cur_hi))
                           : ((cur_lo == 16'h0000) && (cur_hi == 16'hFFFF));
    assign match   = cur_valid
                   && (((snap_src_ip ^ cur_src_ip) & cur_src_mask) == 32'd0)
                   && (((snap_dst_ip ^ cur_dst_ip) & cur_dst_mask) == 32'd0)
                   && ((cur_proto == 8'd0) || (cur_proto == snap_ip_proto))
                   && port_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        snap_load    = 1'b0;
        vd_load      = 1'b0;
        vd_permit_nx = 1'b0;
        vd_hit_nx    = 1'b0;
        vd_rule_nx   = '0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    snap_load = 1'b1;
                    if (bus.eth_proto != ETH_IPV4) begin
                        state_nx     = ST_DONE;
                        vd_load      = 1'b1;
                        vd_permit_nx = NONIP_VERDICT;
                    end else begin
                        state_nx = ST_SCAN;
                        idx_nx   = '0;
                    end
                end
            end
            ST_SCAN: begin
                if (match) begin
                    state_nx     = ST_DONE;
                    vd_load      = 1'b1;
                    vd_permit_nx = cur_action;
                    vd_hit_nx    = 1'b1;
                    vd_rule_nx   = idx;
                end else if (idx == LAST_IDX) begin
                    state_nx     = ST_DONE;
                    vd_load      = 1'b1;
                    vd_permit_nx = DEF_VERDICT;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_ip_proto <= '0;
            snap_src_ip   <= '0;
            snap_dst_ip   <= '0;
            snap_dport    <= '0;
            snap_frag     <= 1'b0;
        end else if (snap_load) begin
            snap_ip_proto <= bus.ip_proto;
            snap_src_ip   <= bus.src_ip;
            snap_dst_ip   <= bus.dst_ip;
            snap_dport    <= bus.dst_port;
            snap_frag     <= bus.is_fragment;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verdict_permit <= 1'b0;
            verdict_hit    <= 1'b0;
            verdict_rule   <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= rise && (state != ST_IDLE);
            if (vd_load) begin
                verdict_permit <= vd_permit_nx;
                verdict_hit    <= vd_hit_nx;
                verdict_rule   <= vd_rule_nx;
            end
        end
    end

    assign verdict_valid      = (state == ST_DONE);
    assign bus.cfg_busy       = (state != ST_IDLE);
    assign bus.verdict_valid  = verdict_valid;
    assign bus.verdict_permit = verdict_permit;
    assign bus.verdict_hit    = verdict_hit;
    assign bus.verdict_rule   = verdict_rule;
    assign bus.overrun        = overrun;

`ifdef FW_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            permit_cnt  <= '0;
            drop_cnt    <= '0;
            overrun_cnt <= '0;
        end else begin
            if (verdict_valid && verdict_permit && (permit_cnt != '1)) begin
                permit_cnt <= permit_cnt + 32'd1;
            end
            if (verdict_valid && !verdict_permit && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (overrun && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
